page_table_walker: RTL

- Refill responder for the TLB: services a TLB miss by walking a two-level page table in RAM and returning the physical page.
- On success, drives the TLB's fault_input/unfault pair. On an invalid PTE, raises page_fault to the core instead.
- Sits between the TLB's fault side and the shared RAM read port, alongside the cache.

---
 rtl/page_table_walker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/page_table_walker.sv
// rtl/page_table_walker.sv - two-level page table walker that refills the TLB from shared RAM
// Walks an Sv32-style split table and either pulses unfault with the physical address or holds page_fault.
module page_table_walker #(
   parameter int bit_count         = 32,
   parameter int page_offset_width = 12,
   parameter int index_width       = 10,
   parameter int walk_count_width  = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   walk_req,
   input  logic [bit_count-1:0]                   vaddr,
   input  logic [bit_count-page_offset_width-1:0] ptbr,
   output logic [bit_count-1:0]                   walk_paddr,
   output logic                                   unfault,
   output logic                                   page_fault,
   output logic                                   busy,
   output logic                                   mem_req,
   output logic [bit_count-1:0]                   mem_addr,
   input  logic                                   mem_ack,
   input  logic [bit_count-1:0]                   mem_rdata,
   output logic [walk_count_width-1:0]            walk_count
);

   localparam int ppn_width = bit_count - page_offset_width;
   localparam int pad_width = page_offset_width - index_width;

   typedef enum logic [2:0] {
      IDLE,
      L1_REQ,
      L2_REQ,
      DONE,
      HOLD,
      ERR
   } state_t;

   state_t                      state_q, state_d;
   logic [bit_count-1:0]        va_q, va_d;
   logic [ppn_width-1:0]        pte1_q, pte1_d;
   logic [bit_count-1:0]        paddr_q, paddr_d;
   logic [walk_count_width-1:0] count_q, count_d;

   // PTE bits [11:1] carry permissions this walker does not enforce.
   logic unused_pte_bits;
   assign unused_pte_bits = ^mem_rdata[page_offset_width-1:1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         va_q    <= '0;
         pte1_q  <= '0;
         paddr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         va_q    <= va_d;
         pte1_q  <= pte1_d;
         paddr_q <= paddr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      va_d       = va_q;
      pte1_d     = pte1_q;
      paddr_d    = paddr_q;
      count_d    = count_q;
      unfault    = 1'b0;
      page_fault = 1'b0;
      busy       = 1'b1;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (walk_req) begin
               va_d    = vaddr;
               state_d = L1_REQ;
            end
         end
         L1_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {ptbr, va_q[bit_count-1 -: index_width], {pad_width{1'b0}}};
            if (mem_ack) begin
               if (mem_rdata[0]) begin
                  pte1_d  = mem_rdata[bit_count-1:page_offset_width];
                  state_d = L2_REQ;
               end else begin
                  state_d = ERR;
               end
            end
         end
         L2_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {pte1_q, va_q[page_offset_width+index_width-1:page_offset_width],
                        {pad_width{1'b0}}};
            if (mem_ack) begin
               if (mem_rdata[0]) begin
                  paddr_d = {mem_rdata[bit_count-1:page_offset_width],
                             va_q[page_offset_width-1:0]};
                  state_d = DONE;
               end else begin
                  state_d = ERR;
               end
            end
         end
         DONE: begin
            unfault = 1'b1;
            count_d = count_q + 1'b1;
            state_d = HOLD;
         end
         // Gives the TLB a cycle to re-compare before walk_req is trusted again.
         HOLD: begin
            state_d = IDLE;
         end
         ERR: begin
            page_fault = 1'b1;
            if (!walk_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign walk_paddr = paddr_q;
   assign walk_count = count_q;

endmodule
